hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Keeps its own M/W destination scoreboard, advanced from E-stage inputs.
- Drives the 2-bit select of both execute-stage forward muxes (operands A and B).
- Generates load-use stalls, branch flushes and data-memory wait stalls, with a memory-timeout watchdog and saturating stall/flush counters.

Parameters:
- TIMEOUT, 16, max consecutive memory-wait cycles before error; valid range 2..255.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- Rs1D  in  5  decode-stage source register 1
- Rs2D  in  5  decode-stage source register 2
- Rs1E  in  5  execute-stage source register 1
- Rs2E  in  5  execute-stage source register 2
- RdE  in  5  execute-stage destination register
- RegWriteE  in  1  execute-stage instruction writes rd
- LoadE  in  1  execute-stage instruction is a load
- PCSrcE  in  1  branch/jump taken in execute
- MemAccessM  in  1  memory-stage load/store request
- MemReadyM  in  1  data memory ready
- ForwardAE  out  2  operand A select: 00 RD1E, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  operand B select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- StallM  out  1  hold EX/MEM register
- StallW  out  1  hold MEM/WB register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register
- MemErr  out  1  sticky memory-timeout error
- StallCount  out  CNT_W  cycles with StallF=1
- FlushCount  out  CNT_W  cycles with FlushE=1

Behaviour:
- Reset (rst_n=0, async): RdM, RdW=0; RegWriteM, RegWriteW=0; state=RUN; wait counter=0; MemErr=0; both counters=0. With inputs at 0, all outputs are 0 / 00.
- Scoreboard: on each clk rise with memStall=0 and state≠ERR:
  - RdM<=RdE; RegWriteM<=RegWriteE&~FlushE.
  - RdW<=RdM; RegWriteW<=RegWriteM.
  - Otherwise all four hold.
- Forwarding (combinational, A shown; B identical using Rs2E):
  - 10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - else 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - else 00.
  - M priority over W when both match. x0 never forwarded.
- lwStall = LoadE & RegWriteE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D) & ~PCSrcE. Branch wins if both are asserted.
- memStall = MemAccessM & ~MemReadyM, or state==ERR.
- Control outputs:
  - StallE=StallM=StallW=memStall.
  - StallF=StallD=lwStall|memStall.
  - FlushD=PCSrcE&~memStall.
  - FlushE=(lwStall|PCSrcE)&~memStall.
- FSM (registered):
  - RUN: memStall condition (excluding ERR term) -> WAIT, wait counter=1.
  - WAIT: MemReadyM=1 or MemAccessM=0 -> RUN, counter=0.
  - WAIT: counter==TIMEOUT-1 with still not ready -> ERR.
  - WAIT: otherwise counter+1.
  - ERR: terminal until reset. MemErr=1, all five stalls=1, flushes=0, scoreboard frozen.
- Timing: stall outputs are combinational from the current inputs, so the stall takes effect in the same cycle. Ready arriving in the same cycle releases the stall in that cycle.
- Counters:
  - Increment on clk rise when the respective signal is 1.
  - Saturate at all-ones, no wrap.
  - Counting continues in ERR (StallCount increments every cycle).
- Reset mid-WAIT or in ERR: immediate return to RUN, all state cleared.

Test Plan:
- RdM=5 (RegWriteE=1, RdE=5, one clk), Rs1E=5, Rs2E=6 -> ForwardAE=10, ForwardBE=00. After one more clk with RdE=0: RdW=5 -> ForwardAE=01.
- Both M and W hold rd=7; Rs2E=7 -> ForwardBE=10. RdE=0 with RegWriteE=1, Rs1E=0 -> ForwardAE=00 after shifting.
- LoadE=1, RegWriteE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1, FlushD=0, StallCount +1 after clk. Same stimulus with PCSrcE=1 -> StallF=0, FlushD=FlushE=1.
- MemAccessM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 -> StallE..StallW=1 for 3 cycles then 0. Scoreboard unchanged during the wait. FlushD suppressed if PCSrcE=1 during the wait.
- TIMEOUT=4, ready held 0 -> after 4 waiting cycles MemErr=1 with all stalls 1. Deassert MemAccessM -> MemErr stays 1. Pulse rst_n=0 mid-cycle -> immediate MemErr=0, counters 0.
- CNT_W=4, hold lwStall for 20 cycles -> StallCount saturates at 15.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// Tracks the M/W destination registers internally, selects the execute-stage
// forward sources, raises load-use / memory-wait stalls and branch flushes,
// and watches for a data memory that never becomes ready.
module hazard_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Watchdog state encoding
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    // Last wait-counter value before declaring a timeout (TIMEOUT is 2..255)
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Forward-mux select codes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Scoreboard of in-flight destinations
    logic [4:0]       r_rd_m;
    logic [4:0]       r_rd_w;
    logic             r_regwrite_m;
    logic             r_regwrite_w;

    // Watchdog
    logic [1:0]       r_state;
    logic [7:0]       r_wait_cnt;

    // Performance counters
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Combinational hazard terms
    logic             w_mem_wait;
    logic             w_err;
    logic             w_mem_stall;
    logic             w_lw_stall;
    logic             w_stall_front;
    logic             w_flush_d;
    logic             w_flush_e;

    // Pick the freshest in-flight producer of rs; x0 is hard-wired to zero
    // and is never forwarded, and the M stage wins over W when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       regwrite_m,
        input logic [4:0] rd_m,
        input logic       regwrite_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] nxt;
        nxt = v;
        if (!(&v)) begin
            nxt = v + CNT_W'(1);
        end
        return nxt;
    endfunction

    // Memory-wait and error terms feed every stall in the same cycle
    assign w_mem_wait  = MemAccessM & ~MemReadyM;
    assign w_err       = (r_state == S_ERR);
    assign w_mem_stall = w_mem_wait | w_err;

    // Load-use hazard; a taken branch squashes the dependent instruction
    // anyway, so it overrides the stall.
    assign w_lw_stall = LoadE & RegWriteE & (RdE != 5'd0) &
                        ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;

    // While memory holds the back end, front-end flushes must wait too,
    // otherwise a squashed instruction would be lost under a frozen pipe.
    assign w_stall_front = w_lw_stall | w_mem_stall;
    assign w_flush_d     = PCSrcE & ~w_mem_stall;
    assign w_flush_e     = (w_lw_stall | PCSrcE) & ~w_mem_stall;

    assign StallF     = w_stall_front;
    assign StallD     = w_stall_front;
    assign StallE     = w_mem_stall;
    assign StallM     = w_mem_stall;
    assign StallW     = w_mem_stall;
    assign FlushD     = w_flush_d;
    assign FlushE     = w_flush_e;
    assign MemErr     = w_err;
    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

    // Forward-mux selects from the current scoreboard contents
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, r_regwrite_m, r_rd_m, r_regwrite_w, r_rd_w);
        ForwardBE = fwd_sel(Rs2E, r_regwrite_m, r_rd_m, r_regwrite_w, r_rd_w);
    end

    // Scoreboard advances with the pipeline and freezes whenever it is held;
    // an instruction flushed out of E must not be remembered as a writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_m       <= 5'd0;
            r_rd_w       <= 5'd0;
            r_regwrite_m <= 1'b0;
            r_regwrite_w <= 1'b0;
        end else if (!w_mem_stall) begin
            r_rd_m       <= RdE;
            r_regwrite_m <= RegWriteE & ~w_flush_e;
            r_rd_w       <= r_rd_m;
            r_regwrite_w <= r_regwrite_m;
        end
    end

    // Memory watchdog: counts consecutive not-ready cycles and locks into
    // the error state once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_wait) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (!w_mem_wait) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Saturating stall/flush performance counters; they keep running in error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_front) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_flush_e) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus a
// randomized run compared against a behavioural reference model.
module tb_hazard_controller;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam longint CMAX = (longint'(1) << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic             RegWriteE, LoadE, PCSrcE, MemAccessM, MemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, StallW;
    logic             FlushD, FlushE, MemErr;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int total;
    int bad;

    hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // In-flight writers, youngest first: idx 0 = M, idx 1 = W.
    typedef struct { bit wr; bit [4:0] rd; } writer_t;
    writer_t inflight[2];
    int      m_wait_run;
    bit      m_err;
    longint  m_stall_cnt;
    longint  m_flush_cnt;

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            inflight[i].wr = 1'b0;
            inflight[i].rd = 5'd0;
        end
        m_wait_run  = 0;
        m_err       = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endfunction

    function automatic bit [1:0] model_fwd(input bit [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        for (int i = 0; i < 2; i++)
            if (inflight[i].wr && inflight[i].rd == rs)
                return (i == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_mem_hold();
        return (MemAccessM && !MemReadyM) || m_err;
    endfunction

    function automatic bit model_lw();
        return LoadE && RegWriteE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
    endfunction

    // Advance the model with the current inputs, then let the DUT see the edge
    task automatic tick();
        bit hold, lw, fe;
        hold = model_mem_hold();
        lw   = model_lw();
        fe   = (lw || PCSrcE) && !hold;
        if (lw || hold)
            m_stall_cnt = (m_stall_cnt < CMAX) ? m_stall_cnt + 1 : m_stall_cnt;
        if (fe)
            m_flush_cnt = (m_flush_cnt < CMAX) ? m_flush_cnt + 1 : m_flush_cnt;
        if (!hold) begin
            inflight[1]    = inflight[0];
            inflight[0].wr = RegWriteE && !fe;
            inflight[0].rd = RdE;
        end
        if (!m_err) begin
            if (MemAccessM && !MemReadyM) begin
                m_wait_run++;
                if (m_wait_run >= TIMEOUT) m_err = 1'b1;
            end else begin
                m_wait_run = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
        RegWriteE = 0; LoadE = 0; PCSrcE = 0; MemAccessM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        model_clear();
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_clear();
        #1;
        total++;
        if ({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr});
        end
        total++;
        if (StallCount !== '0 || FlushCount !== '0) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", StallCount, FlushCount);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        total++;
        if (MemErr !== 1'b0 || StallF !== 1'b0) begin
            bad++;
            $display("FAIL reset_release memerr=%b stallf=%b want=0/0", MemErr, StallF);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        RegWriteE = 1; RdE = 5;
        tick();
        RegWriteE = 0; RdE = 0; Rs1E = 5; Rs2E = 6;
        #1;
        total++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
            bad++;
            $display("FAIL fwd_from_m A=%b B=%b want=10/00", ForwardAE, ForwardBE);
        end
        tick();
        total++;
        if (ForwardAE !== 2'b01) begin
            bad++;
            $display("FAIL fwd_from_w A=%b want=01", ForwardAE);
        end
        do_reset();
        RegWriteE = 1; RdE = 7;
        tick();
        tick();
        Rs2E = 7; RegWriteE = 0;
        #1;
        total++;
        if (ForwardBE !== 2'b10) begin
            bad++;
            $display("FAIL fwd_m_priority B=%b want=10", ForwardBE);
        end
        RegWriteE = 1; RdE = 0; Rs1E = 0;
        tick();
        tick();
        total++;
        if (ForwardAE !== 2'b00) begin
            bad++;
            $display("FAIL fwd_x0 A=%b want=00", ForwardAE);
        end
        Rs1E = 7;
        #1;
        total++;
        if (ForwardAE !== 2'b00) begin
            bad++;
            $display("FAIL fwd_shifted_out A=%b want=00", ForwardAE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        LoadE = 1; RegWriteE = 1; RdE = 3; Rs2D = 3;
        #1;
        total++;
        if ({StallF, StallD, FlushE, FlushD, StallE} !== 5'b11100) begin
            bad++;
            $display("FAIL lw_stall F,D,FE,FD,E=%b want=11100", {StallF, StallD, FlushE, FlushD, StallE});
        end
        tick();
        total++;
        if (StallCount !== 4'd1 || FlushCount !== 4'd1) begin
            bad++;
            $display("FAIL lw_count stall=%0d flush=%0d want=1/1", StallCount, FlushCount);
        end
        Rs1E = 3;
        #1;
        total++;
        if (ForwardAE !== 2'b00) begin
            bad++;
            $display("FAIL lw_bubble_not_tracked A=%b want=00", ForwardAE);
        end
        PCSrcE = 1;
        #1;
        total++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            bad++;
            $display("FAIL branch_wins F,D,FD,FE=%b want=0011", {StallF, StallD, FlushD, FlushE});
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        RegWriteE = 1; RdE = 4;
        tick();
        RegWriteE = 1; RdE = 9; Rs1E = 4; PCSrcE = 1;
        MemAccessM = 1; MemReadyM = 0;
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            #1;
            total++;
            if ({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE} !== 9'b11111_00_10) begin
                bad++;
                $display("FAIL mem_wait_%0d got=%b want=111110010", k, {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE});
            end
            tick();
        end
        MemReadyM = 1;
        #1;
        total++;
        if ({StallE, StallM, StallW, FlushD, MemErr} !== 5'b00010) begin
            bad++;
            $display("FAIL mem_release E,M,W,FD,err=%b want=00010", {StallE, StallM, StallW, FlushD, MemErr});
        end
        tick();
        total++;
        if (MemErr !== 1'b0 || StallCount !== 4'd3) begin
            bad++;
            $display("FAIL mem_no_timeout err=%b stallcnt=%0d want=0/3", MemErr, StallCount);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        MemAccessM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int k = 0; k < TIMEOUT; k++) begin
            #1;
            total++;
            if (MemErr !== 1'b0 || StallE !== 1'b1) begin
                bad++;
                $display("FAIL timeout_early_%0d err=%b stalle=%b want=0/1", k, MemErr, StallE);
            end
            tick();
        end
        total++;
        if ({MemErr, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE} !== 8'b1111_1100) begin
            bad++;
            $display("FAIL timeout_err got=%b want=11111100", {MemErr, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE});
        end
        total++;
        if (StallCount !== 4'd4 || FlushCount !== 4'd0) begin
            bad++;
            $display("FAIL timeout_counts stall=%0d flush=%0d want=4/0", StallCount, FlushCount);
        end
        MemAccessM = 0; PCSrcE = 0; RegWriteE = 1; RdE = 8; Rs1E = 8;
        tick();
        tick();
        total++;
        if (MemErr !== 1'b1 || StallF !== 1'b1 || ForwardAE !== 2'b00 || StallCount !== 4'd6) begin
            bad++;
            $display("FAIL err_sticky err=%b stallf=%b A=%b stallcnt=%0d want=1/1/00/6", MemErr, StallF, ForwardAE, StallCount);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (MemErr !== 1'b0 || StallCount !== '0 || FlushCount !== '0 || StallF !== 1'b0) begin
            bad++;
            $display("FAIL async_reset err=%b stall=%0d flush=%0d stallf=%b want=0/0/0/0", MemErr, StallCount, FlushCount, StallF);
        end
        rst_n = 1'b1;
        clear_inputs();
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        do_reset();
        LoadE = 1; RegWriteE = 1; RdE = 3; Rs1D = 3;
        for (int k = 0; k < 15; k++) tick();
        total++;
        if (StallCount !== 4'd15) begin
            bad++;
            $display("FAIL sat_reach stall=%0d want=15", StallCount);
        end
        for (int k = 0; k < 5; k++) tick();
        total++;
        if (StallCount !== 4'd15 || FlushCount !== 4'd15) begin
            bad++;
            $display("FAIL sat_hold stall=%0d flush=%0d want=15/15", StallCount, FlushCount);
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_vec;
        bit hold, lw;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            Rs1D       = 5'($urandom_range(0, 7));
            Rs2D       = 5'($urandom_range(0, 7));
            Rs1E       = 5'($urandom_range(0, 7));
            Rs2E       = 5'($urandom_range(0, 7));
            RdE        = 5'($urandom_range(0, 7));
            RegWriteE  = ($urandom_range(0, 3) != 0);
            LoadE      = ($urandom_range(0, 3) == 0);
            PCSrcE     = ($urandom_range(0, 5) == 0);
            MemAccessM = ($urandom_range(0, 2) == 0);
            MemReadyM  = ($urandom_range(0, 4) != 0);
            #1;
            hold = model_mem_hold();
            lw   = model_lw();
            exp_vec = {model_fwd(Rs1E), model_fwd(Rs2E), lw || hold, lw || hold,
                       hold, hold, hold, PCSrcE && !hold, (lw || PCSrcE) && !hold, m_err};
            total++;
            if ({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr} !== exp_vec) begin
                bad++;
                $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", i,
                         {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr}, exp_vec);
            end
            total++;
            if (StallCount !== CNT_W'(m_stall_cnt) || FlushCount !== CNT_W'(m_flush_cnt)) begin
                bad++;
                $display("FAIL rand_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, StallCount, FlushCount, m_stall_cnt, m_flush_cnt);
            end
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk); #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
